hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. Generates per-stage register enables and flushes.
- Handles three hazard classes:
  - Load-use stalls that EX-stage forwarding cannot cover.
  - Taken-branch squashes.
  - Multi-cycle data-memory waits, with a timeout watchdog.
- Sits beside the forwarding unit and drives the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- MEM_TIMEOUT, 16, max consecutive frozen cycles waiting on mem_ready before error (range 2..255)
- CNT_W, 32, width of performance counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- rs1_id  input  5  rs1 of instruction in ID
- rs2_id  input  5  rs2 of instruction in ID
- rs1_used_id  input  1  ID instruction reads rs1
- rs2_used_id  input  1  ID instruction reads rs2
- rd_ex  input  5  rd of instruction in EX
- dmrd_ex  input  1  EX instruction is a load
- branch_taken_ex  input  1  branch/jump resolved taken in EX
- mem_req_mem  input  1  MEM instruction accesses data memory
- mem_ready  input  1  data memory completes access this cycle
- pc_en  output  1  PC update enable
- ifid_en  output  1  IF/ID enable
- ifid_flush  output  1  IF/ID load NOP
- idex_en  output  1  ID/EX enable
- idex_flush  output  1  ID/EX load NOP
- exmem_en  output  1  EX/MEM enable
- memwb_flush  output  1  MEM/WB load NOP
- mem_err  output  1  sticky memory-timeout error
- stall_cycles  output  CNT_W  frozen + load-use cycles (see optional feature)
- flush_count  output  CNT_W  taken-branch flush events (see optional feature)

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values: state=RUN, wait_cnt=0, mem_err=0, counters=0.
- While rst=1, all enables are 0 and all flushes are 0.
- FSM states:
  - RUN
  - MEM_WAIT
  - ERR
- Outputs are Mealy: computed from state and current inputs in the same cycle. Zero-latency stall is required.
- Freeze condition F:
  - (state=RUN and mem_req_mem and !mem_ready), or
  - (state=MEM_WAIT and !mem_ready), or
  - state=ERR.
- When F=1:
  - pc_en = ifid_en = idex_en = exmem_en = 0.
  - memwb_flush = 1.
  - ifid_flush = idex_flush = 0.
  - Branch and load-use are ignored; they are re-evaluated once unfrozen.
- When F=0, priority is branch over load-use:
  - Branch: branch_taken_ex=1 gives ifid_flush=1, idex_flush=1, all enables 1.
  - Load-use: LU = dmrd_ex and rd_ex!=0 and ((rs1_used_id and rs1_id==rd_ex) or (rs2_used_id and rs2_id==rd_ex)). If LU=1 and no branch: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1.
  - Otherwise: all enables 1, all flushes 0.
- Transitions:
  - RUN -> MEM_WAIT when mem_req_mem and !mem_ready; wait_cnt<=1.
  - MEM_WAIT -> RUN when mem_ready. The pipeline advances in that same cycle.
  - MEM_WAIT, !mem_ready: wait_cnt++. If wait_cnt==MEM_TIMEOUT-1, go to ERR and set mem_err<=1.
  - ERR: held until rst. mem_ready is ignored.
- A mem_ready pulse in RUN with no request has no effect.
- rd_ex==0 never stalls.
- Reset mid-MEM_WAIT returns to RUN immediately and clears wait_cnt.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cycles increments on each cycle with F=1 or LU-stall.
  - flush_count increments on each unfrozen taken-branch cycle.
  - Both wrap at 2^CNT_W.
- HAZARD_PERF_EN undefined: both outputs are tied to 0; no counter flops are inferred.

Decomposition:
- Shared package hazard_pkg holds:
  - State enum: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2.
  - Register-index width constant REG_AW=5.
- Sub-module hazard_lu_detect: combinational load-use comparator producing LU.
- FSM, watchdog and counters stay in hazard_ctrl.

Test Plan:
- Load-use: dmrd_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle. Same stimulus with rd_ex=0 -> no stall.
- Branch plus load-use in the same cycle: branch_taken_ex=1, LU=1 -> ifid_flush=1, idex_flush=1, pc_en=1; flush_count +1 (perf on).
- Memory wait: mem_req_mem=1, mem_ready low 3 cycles then high -> 3 frozen cycles with memwb_flush=1; 4th cycle all enables 1; state returns to RUN.
- Timeout, MEM_TIMEOUT=4, mem_ready held 0 -> ERR after 4 frozen cycles; mem_err=1 sticky; pipeline frozen until rst.
- Branch during freeze: branch_taken_ex=1 while frozen -> no flush until mem_ready=1, then flush in that cycle.
- Async reset asserted mid-MEM_WAIT between clock edges -> outputs drop immediately; after release, state=RUN, mem_err=0, counters=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding and register-index width for the hazard controller
package hazard_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from the pipeline and per-stage enable/flush controls back to it
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  import hazard_pkg::*;
  logic [REG_AW-1:0] rs1_id, rs2_id, rd_ex;
  logic rs1_used_id, rs2_used_id, dmrd_ex, branch_taken_ex, mem_req_mem, mem_ready;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  modport master (
    output rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, dmrd_ex, branch_taken_ex, mem_req_mem, mem_ready,
    input pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err, stall_cycles, flush_count
  );
  modport slave (
    input rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, dmrd_ex, branch_taken_ex, mem_req_mem, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: flags a load in EX whose destination is read by the instruction in ID
module hazard_lu_detect
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic              dmrd_ex,
  output logic              lu
);
  assign lu = dmrd_ex && rd_ex != '0 &&
              ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Mealy pipeline sequencer for load-use stalls, branch squashes and memory waits with watchdog.
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise they read as zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);
  state_t state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic mem_err, lu, frz, br, lu_stall;
  hazard_lu_detect u_lu (
    .rs1_id      (bus.rs1_id),
    .rs2_id      (bus.rs2_id),
    .rd_ex       (bus.rd_ex),
    .rs1_used_id (bus.rs1_used_id),
    .rs2_used_id (bus.rs2_used_id),
    .dmrd_ex     (bus.dmrd_ex),
    .lu          (lu)
  );
  always_comb begin
    frz = (state == RUN && bus.mem_req_mem && !bus.mem_ready) ||
          (state == MEM_WAIT && !bus.mem_ready) || state == ERR;
    br = !frz && bus.branch_taken_ex;
    lu_stall = !frz && !bus.branch_taken_ex && lu;
    state_nxt = state == RUN ? (bus.mem_req_mem && !bus.mem_ready ? MEM_WAIT : RUN) :
                state == MEM_WAIT ? (bus.mem_ready ? RUN :
                                     wait_cnt == 8'(MEM_TIMEOUT - 1) ? ERR : MEM_WAIT) : ERR;
    wait_nxt = state_nxt == MEM_WAIT ? wait_cnt + 8'd1 : '0;
  end
  // Gating with rst keeps every enable and flush low for the whole reset assertion.
  always_comb begin
    bus.pc_en       = !rst && !frz && !lu_stall;
    bus.ifid_en     = !rst && !frz && !lu_stall;
    bus.ifid_flush  = !rst && br;
    bus.idex_en     = !rst && !frz;
    bus.idex_flush  = !rst && (br || lu_stall);
    bus.exmem_en    = !rst && !frz;
    bus.memwb_flush = !rst && frz;
    bus.mem_err     = mem_err;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= mem_err || state_nxt == ERR;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(frz || lu_stall);
      flush_q <= flush_q + CNT_W'(br);
    end
  end
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = CNT_W'(0);
  assign bus.flush_count  = CNT_W'(0);
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with MEM_TIMEOUT=4; counter expectations follow HAZARD_PERF_EN
module tb_hazard_ctrl;
  localparam logic [7:0] RST_O = 8'b0000_0000;
  localparam logic [7:0] NORM  = 8'b1101_0100;
  localparam logic [7:0] LUS   = 8'b0001_1100;
  localparam logic [7:0] BRF   = 8'b1111_1100;
  localparam logic [7:0] FRZ   = 8'b0000_0010;
  localparam logic [7:0] ERRF  = 8'b0000_0011;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  logic [31:0] exp_st = 0, exp_fl = 0;
  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(hif.slave));
  always #5 clk = ~clk;
  wire [7:0] outs = {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
                     hif.idex_flush, hif.exmem_en, hif.memwb_flush, hif.mem_err};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [7:0] e, input int ds, input int df);
    #1;
    chk(tag, 32'(outs), 32'(e));
    chk({tag, "_stall"}, hif.stall_cycles, exp_st);
    chk({tag, "_flush"}, hif.flush_count, exp_fl);
    @(posedge clk);
`ifdef HAZARD_PERF_EN
    exp_st += 32'(ds);
    exp_fl += 32'(df);
`endif
    #2;
  endtask
  task automatic idle();
    hif.rs1_id = 0; hif.rs2_id = 0; hif.rd_ex = 0; hif.rs1_used_id = 0; hif.rs2_used_id = 0;
    hif.dmrd_ex = 0; hif.branch_taken_ex = 0; hif.mem_req_mem = 0; hif.mem_ready = 0;
  endtask
  initial begin
    idle();
    hif.mem_req_mem = 1; hif.branch_taken_ex = 1;
    #1;
    chk("reset_outs", 32'(outs), 32'(RST_O));
    chk("reset_stall", hif.stall_cycles, 0);
    @(posedge clk); #2;
    rst = 0; idle();
    step("idle", NORM, 0, 0);
    hif.dmrd_ex = 1; hif.rd_ex = 5; hif.rs1_id = 5; hif.rs1_used_id = 1;
    step("lu_rs1", LUS, 1, 0);
    idle();
    step("lu_done", NORM, 0, 0);
    hif.dmrd_ex = 1; hif.rd_ex = 7; hif.rs2_id = 7; hif.rs2_used_id = 1;
    step("lu_rs2", LUS, 1, 0);
    hif.rs2_used_id = 0;
    step("lu_rs2_unused", NORM, 0, 0);
    idle(); hif.dmrd_ex = 1; hif.rs1_used_id = 1;
    step("lu_rd0", NORM, 0, 0);
    hif.rd_ex = 5; hif.rs1_id = 5; hif.branch_taken_ex = 1;
    step("br_lu", BRF, 0, 1);
    idle(); hif.mem_req_mem = 1;
    step("mw1", FRZ, 1, 0);
    step("mw2", FRZ, 1, 0);
    step("mw3", FRZ, 1, 0);
    hif.mem_ready = 1;
    step("mw_done", NORM, 0, 0);
    idle();
    step("mw_run", NORM, 0, 0);
    hif.mem_ready = 1;
    step("stray_ready", NORM, 0, 0);
    idle(); hif.mem_req_mem = 1; hif.branch_taken_ex = 1;
    step("br_frozen1", FRZ, 1, 0);
    step("br_frozen2", FRZ, 1, 0);
    hif.mem_ready = 1;
    step("br_unfrozen", BRF, 0, 1);
    idle(); hif.mem_req_mem = 1;
    step("mw_enter", FRZ, 1, 0);
    #1 rst = 1;
    #1;
    chk("async_rst_outs", 32'(outs), 32'(RST_O));
    chk("async_rst_stall", hif.stall_cycles, 0);
    chk("async_rst_flush", hif.flush_count, 0);
    exp_st = 0; exp_fl = 0;
    #1 rst = 0; idle();
    step("post_rst", NORM, 0, 0);
    hif.mem_req_mem = 1;
    step("to1", FRZ, 1, 0);
    step("to2", FRZ, 1, 0);
    step("to3", FRZ, 1, 0);
    step("to4", FRZ, 1, 0);
    step("err1", ERRF, 1, 0);
    hif.mem_ready = 1; hif.branch_taken_ex = 1;
    step("err_ready", ERRF, 1, 0);
    idle();
    step("err_idle", ERRF, 1, 0);
    rst = 1;
    #1;
    chk("err_rst_outs", 32'(outs), 32'(RST_O));
    @(posedge clk); #2;
    rst = 0; exp_st = 0; exp_fl = 0;
    step("err_cleared", NORM, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
